// File: rtl/alu_match_seq.sv
// Multi-cycle bit-pattern search beside the EX-stage ALU.
// Slides a PAT_W window over DATA_W bits, one position per cycle.
module alu_match_seq #(
  parameter int DATA_W = 32,
  parameter int PAT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [DATA_W-1:0] data,
  input  logic              flush,
  output logic              busy,
  output logic              result_valid,
  output logic              found,
  output logic [DATA_W-1:0] result
);

  localparam int N     = DATA_W - PAT_W + 1;
  localparam int IDX_W = $clog2(N + 1);

  localparam logic [IDX_W-1:0] TOP  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] NPOS = IDX_W'(N);

  localparam logic [1:0] M_FIRST = 2'b00;
  localparam logic [1:0] M_LAST  = 2'b01;
  localparam logic [1:0] M_COUNT = 2'b10;
  localparam logic [1:0] M_MASK  = 2'b11;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        mode_q, mode_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              found_q, found_d;
  logic              valid_q, valid_d;

  logic [PAT_W-1:0]  win;
  logic              hit;
  logic              last_pos;
  logic              done;
  logic [IDX_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] mask_nxt;
  logic [DATA_W-1:0] res_c;
  logic              found_c;

  // Per-position datapath for the window under the cursor.
  always_comb begin
    win      = PAT_W'(data_q >> cur_q);
    hit      = (win == pat_q);
    cnt_nxt  = cnt_q + IDX_W'(hit);
    mask_nxt = mask_q | (DATA_W'(hit) << cur_q);
    if (mode_q == M_LAST) begin
      last_pos = (cur_q == '0);
    end else begin
      last_pos = (cur_q == TOP);
    end
  end

  // Completion condition and candidate result.
  always_comb begin
    done    = 1'b0;
    res_c   = '0;
    found_c = 1'b0;
    unique case (mode_q)
      M_FIRST, M_LAST: begin
        done    = hit | last_pos;
        res_c   = hit ? DATA_W'(cur_q) : DATA_W'(NPOS);
        found_c = hit;
      end
      M_COUNT: begin
        done    = last_pos;
        res_c   = DATA_W'(cnt_nxt);
        found_c = (cnt_nxt != '0);
      end
      M_MASK: begin
        done    = last_pos;
        res_c   = mask_nxt;
        found_c = (mask_nxt != '0);
      end
      default: begin
        done    = last_pos;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    data_d  = data_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    res_d   = res_q;
    found_d = found_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = SCAN;
          mode_d  = mode;
          pat_d   = pattern;
          data_d  = data;
          cur_d   = (mode == M_LAST) ? TOP : '0;
          cnt_d   = '0;
          mask_d  = '0;
        end
      end
      SCAN: begin
        // Flush wins over a completion on the same edge.
        if (flush) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          res_d   = res_c;
          found_d = found_c;
          valid_d = 1'b1;
        end else begin
          cnt_d  = cnt_nxt;
          mask_d = mask_nxt;
          if (mode_q == M_LAST) begin
            cur_d = cur_q - 1'b1;
          end else begin
            cur_d = cur_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      res_q   <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign result_valid = valid_q;
  assign found        = found_q;
  assign result       = res_q;

endmodule

// File: tb/tb_alu_match_seq.sv
// Self-checking bench for alu_match_seq.
// Random and directed searches against a loop-based reference model.
module tb_alu_match_seq;

  localparam int DW = 32;
  localparam int PW = 8;
  localparam int NP = DW - PW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [PW-1:0] pattern;
  logic [DW-1:0] data;
  logic          flush;
  logic          busy;
  logic          result_valid;
  logic          found;
  logic [DW-1:0] result;

  int nchk  = 0;
  int nfail = 0;

  alu_match_seq #(.DATA_W(DW), .PAT_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .pattern      (pattern),
    .data         (data),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .found        (found),
    .result       (result)
  );

  initial forever #5 clk = ~clk;

  function automatic void model(input logic [1:0] m, input logic [PW-1:0] p,
                                input logic [DW-1:0] d,
                                output logic [DW-1:0] r, output logic f,
                                output int lat);
    logic [DW-1:0] hits;
    int cnt, first, last;
    hits = '0; cnt = 0; first = -1; last = -1;
    for (int i = 0; i < NP; i++) begin
      if (d[i +: PW] == p) begin
        hits[i] = 1'b1;
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    case (m)
      2'b00: begin
        r   = (first >= 0) ? DW'(first) : DW'(NP);
        f   = (first >= 0);
        lat = (first >= 0) ? first + 1 : NP;
      end
      2'b01: begin
        r   = (last >= 0) ? DW'(last) : DW'(NP);
        f   = (last >= 0);
        lat = (last >= 0) ? NP - last : NP;
      end
      2'b10: begin
        r = DW'(cnt); f = (cnt != 0); lat = NP;
      end
      default: begin
        r = hits; f = (hits != '0); lat = NP;
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] m, input logic [PW-1:0] p,
                        input logic [DW-1:0] d);
    mode = m; pattern = p; data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); pattern = PW'($urandom); data = $urandom;
  endtask

  task automatic wait_done(input int lat, input logic [DW-1:0] er,
                           input logic ef, input string nm);
    int k;
    k = 0;
    nchk++;
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL %s busy_after_T0 got %b want 1", nm, busy);
    end
    while (result_valid !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    nchk++;
    if (k !== lat) begin
      nfail++; $display("FAIL %s latency got %0d want %0d", nm, k, lat);
    end
    nchk++;
    if (result !== er) begin
      nfail++; $display("FAIL %s result got %h want %h", nm, result, er);
    end
    nchk++;
    if (found !== ef) begin
      nfail++; $display("FAIL %s found got %b want %b", nm, found, ef);
    end
    nchk++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL %s busy_at_done got %b want 0", nm, busy);
    end
  endtask

  task automatic do_search(input logic [1:0] m, input logic [PW-1:0] p,
                           input logic [DW-1:0] d, input string nm);
    logic [DW-1:0] er; logic ef; int lat;
    model(m, p, d, er, ef, lat);
    launch(m, p, d);
    wait_done(lat, er, ef, nm);
    @(negedge clk);
    nchk++;
    if (result_valid !== 1'b0) begin
      nfail++; $display("FAIL %s valid_pulse_width got %b want 0", nm, result_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    mode = '0; pattern = '0; data = '0;
    repeat (2) @(negedge clk);
    nchk++;
    if ({busy, result_valid, found, result} !== '0) begin
      nfail++;
      $display("FAIL reset outs got %b%b%b %h want 0", busy, result_valid, found, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_search(2'b00, 8'hFF, 32'h0000FF00, "first_ff");
    do_search(2'b01, 8'hFF, 32'h0000FF00, "last_ff");
    do_search(2'b10, 8'hFF, 32'h0001FF00, "count_ff");
    do_search(2'b11, 8'hFF, 32'h0001FF00, "mask_ff");
    do_search(2'b00, 8'hA5, 32'h00000000, "first_nomatch");
    do_search(2'b01, 8'hA5, 32'h00000000, "last_nomatch");
    do_search(2'b10, 8'h55, 32'h55555555, "count_overlap");
    do_search(2'b11, 8'h00, 32'h00000000, "mask_all");
    do_search(2'b00, 8'hAB, 32'h00000000 | 8'hAB, "first_pos0");
    do_search(2'b01, 8'hCD, 32'hCD000000, "last_top");
  endtask

  task automatic test_random;
    logic [1:0] m; logic [PW-1:0] p; logic [DW-1:0] d; int nins, pos;
    for (int it = 0; it < 40; it++) begin
      m = 2'($urandom_range(0, 3));
      p = PW'($urandom);
      d = $urandom;
      nins = $urandom_range(0, 3);
      for (int j = 0; j < nins; j++) begin
        pos = $urandom_range(0, NP - 1);
        d[pos +: PW] = p;
      end
      do_search(m, p, d, $sformatf("rand%0d", it));
    end
  endtask

  task automatic test_flush;
    int seen;
    do_search(2'b00, 8'hFF, 32'h0000FF00, "pre_flush");
    launch(2'b10, 8'hFF, 32'h0001FF00);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    nchk++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      nfail++; $display("FAIL flush_stop busy/valid got %b/%b want 0/0", busy, result_valid);
    end
    nchk++;
    if (result !== 32'd8 || found !== 1'b1) begin
      nfail++; $display("FAIL flush_hold result/found got %h/%b want 8/1", result, found);
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (result_valid === 1'b1 || busy === 1'b1) seen++;
    end
    nchk++;
    if (seen !== 0) begin
      nfail++; $display("FAIL flush_quiet activity cycles got %0d want 0", seen);
    end
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    nchk++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL flush_start_idle busy got %b want 0", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    nchk++;
    if (result !== 32'd8 || found !== 1'b1 || busy !== 1'b0) begin
      nfail++; $display("FAIL flush_idle result/found got %h/%b want 8/1", result, found);
    end
  endtask

  task automatic test_start_held;
    int pulses, t1, t2;
    pulses = 0; t1 = -1; t2 = -1;
    mode = 2'b00; pattern = 8'hFF; data = 32'h0000FF00; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        pulses++;
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    start = 1'b0;
    nchk++;
    if (pulses !== 2 || t1 !== 9 || t2 !== 19) begin
      nfail++;
      $display("FAIL start_held pulses/t1/t2 got %0d/%0d/%0d want 2/9/19", pulses, t1, t2);
    end
    repeat (12) @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || result !== 32'd8 || found !== 1'b1) begin
      nfail++; $display("FAIL start_held_drain busy/result got %b/%h want 0/8", busy, result);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] er; logic ef; int lat;
    launch(2'b01, 8'hFF, 32'h0000FF00);
    wait_done(17, 32'd8, 1'b1, "b2b_a");
    model(2'b11, 8'h0F, 32'h0F0F0F0F, er, ef, lat);
    launch(2'b11, 8'h0F, 32'h0F0F0F0F);
    wait_done(lat, er, ef, "b2b_b");
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    do_search(2'b11, 8'hFF, 32'h0001FF00, "pre_reset");
    launch(2'b10, 8'hFF, 32'h0001FF00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    nchk++;
    if ({busy, result_valid, found, result} !== '0) begin
      nfail++;
      $display("FAIL reset_mid outs got %b%b%b %h want 0", busy, result_valid, found, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_search(2'b00, 8'hA5, 32'h00000000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
